// File: rtl/tblink_rpc_clkctrl.sv
// tblink_rpc_clkctrl: local command endpoint executing capture, clock-advance and set commands.
// Responses are returned as one or two bytes on the i_ stream; cclock_en gates the cclock divider.
module tblink_rpc_clkctrl #(
    parameter int ADV_SHIFT = 0
) (
    input  logic       uclock,
    input  logic       reset,
    input  logic [7:0] t_dat,
    input  logic       t_valid,
    output logic       t_ready,
    output logic [7:0] i_dat,
    output logic       i_valid,
    input  logic       i_ready,
    output logic       cclock_en,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       busy
);
    localparam int CW = 6 + ADV_SHIFT;

    typedef enum logic [2:0] {IDLE, ADV, SETD, RSP0, RSP1} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      rsp0_q;
    logic [7:0]      rsp1_q;
    logic [7:0]      dat_q;
    logic            two_q;
    logic [CW-1:0]   adv_ld;
    logic            t_acc;

    assign adv_ld = CW'(t_dat[7:2]) << ADV_SHIFT;
    assign t_acc  = t_valid & t_ready;

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rsp0_q  <= 8'h00;
            rsp1_q  <= 8'h00;
            dat_q   <= 8'h00;
            two_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (t_acc) begin
                    two_q <= (t_dat[1:0] == 2'b00);
                    case (t_dat[1:0])
                        2'b00: begin
                            rsp0_q  <= 8'h00;
                            rsp1_q  <= dat_i;
                            state_q <= RSP0;
                        end
                        2'b01: begin
                            cnt_q   <= adv_ld;
                            rsp0_q  <= 8'h01;
                            state_q <= (adv_ld == '0) ? RSP0 : ADV;
                        end
                        2'b10: state_q <= SETD;
                        default: begin
                            rsp0_q  <= 8'hFF;
                            state_q <= RSP0;
                        end
                    endcase
                end
                ADV: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rsp0_q  <= 8'h01;
                        state_q <= RSP0;
                    end
                end
                // the byte after SET is always data, never decoded as a command
                SETD: if (t_acc) begin
                    dat_q   <= t_dat;
                    rsp0_q  <= 8'h02;
                    two_q   <= 1'b0;
                    state_q <= RSP0;
                end
                RSP0: if (i_ready) state_q <= two_q ? RSP1 : IDLE;
                RSP1: if (i_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign t_ready   = (state_q == IDLE) || (state_q == SETD);
    assign i_valid   = (state_q == RSP0) || (state_q == RSP1);
    assign i_dat     = (state_q == RSP1) ? rsp1_q : (state_q == RSP0) ? rsp0_q : 8'h00;
    assign cclock_en = (state_q == ADV);
    assign busy      = (state_q != IDLE);
    assign dat_o     = dat_q;
endmodule

// File: tb/tb_tblink_rpc_clkctrl.sv
// tb_tblink_rpc_clkctrl: randomized command stream against a transaction-level model of the endpoint.
module tb_tblink_rpc_clkctrl;
    localparam int SH = 0;

    logic       uclock;
    logic       reset;
    logic [7:0] t_dat;
    logic       t_valid;
    logic       t_ready;
    logic [7:0] i_dat;
    logic       i_valid;
    logic       i_ready;
    logic       cclock_en;
    logic [7:0] dat_i;
    logic [7:0] dat_o;
    logic       busy;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] mdl_dat = 8'h00;

    tblink_rpc_clkctrl #(.ADV_SHIFT(SH)) dut (
        .uclock(uclock), .reset(reset),
        .t_dat(t_dat), .t_valid(t_valid), .t_ready(t_ready),
        .i_dat(i_dat), .i_valid(i_valid), .i_ready(i_ready),
        .cclock_en(cclock_en), .dat_i(dat_i), .dat_o(dat_o), .busy(busy)
    );

    initial uclock = 1'b0;
    always #5 uclock = ~uclock;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    // offer one byte on t_ and return at the negedge after it was accepted
    task automatic send(input logic [7:0] b);
        int   n;
        logic acc;
        n = 0;
        t_dat = b;
        t_valid = 1'b1;
        do begin
            acc = t_ready;
            @(negedge uclock);
            n++;
        end while (!acc && n < 100);
        t_valid = 1'b0;
        check("accept", 32'(acc), 1);
    endtask

    // issue one command and verify timing, cclock_en cycles and response bytes
    task automatic do_cmd(input logic [7:0] cmd, input logic [7:0] data, input int gap,
                          input int bp, input logic [7:0] din);
        logic [7:0] e[$];
        int         exp_en;
        int         lat;
        int         en;
        int         w;
        dat_i = din;
        send(cmd);
        dat_i = 8'($urandom);
        exp_en = 0;
        case (cmd[1:0])
            2'b00: begin e.push_back(8'h00); e.push_back(din); end
            2'b01: begin exp_en = int'(cmd[7:2]) << SH; e.push_back(8'h01); end
            2'b10: begin
                for (int j = 0; j < gap; j++) begin
                    check("setd_ready", 32'(t_ready), 1);
                    check("setd_busy", 32'(busy), 1);
                    @(negedge uclock);
                end
                send(data);
                mdl_dat = data;
                check("set_dat_o", 32'(dat_o), 32'(mdl_dat));
                e.push_back(8'h02);
            end
            default: e.push_back(8'hFF);
        endcase
        lat = 1;
        en = 0;
        while (!i_valid && lat < 300) begin
            en += int'(cclock_en);
            @(negedge uclock);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_en + 1));
        check("en_cycles", 32'(en), 32'(exp_en));
        check("en_off_rsp", 32'(cclock_en), 0);
        foreach (e[i]) begin
            w = (bp >= 0) ? bp : int'($urandom_range(0, 3));
            i_ready = 1'b0;
            t_dat = 8'h03;
            t_valid = 1'b1;
            for (int j = 0; j < w; j++) begin
                check("hold_valid", 32'(i_valid), 1);
                check("hold_dat", 32'(i_dat), 32'(e[i]));
                check("refuse_cmd", 32'(t_ready), 0);
                @(negedge uclock);
            end
            i_ready = 1'b1;
            check("rsp_valid", 32'(i_valid), 1);
            check("rsp_dat", 32'(i_dat), 32'(e[i]));
            @(negedge uclock);
            i_ready = 1'b0;
        end
        t_valid = 1'b0;
        check("idle_busy", 32'(busy), 0);
        check("idle_ready", 32'(t_ready), 1);
        check("idle_ivalid", 32'(i_valid), 0);
        check("dat_o", 32'(dat_o), 32'(mdl_dat));
    endtask

    initial begin
        int quiet;
        reset = 1'b1;
        t_dat = 8'h00;
        t_valid = 1'b0;
        i_ready = 1'b0;
        dat_i = 8'h00;
        repeat (2) @(negedge uclock);
        check("rst_tready", 32'(t_ready), 1);
        check("rst_ivalid", 32'(i_valid), 0);
        check("rst_idat", 32'(i_dat), 0);
        check("rst_en", 32'(cclock_en), 0);
        check("rst_dat_o", 32'(dat_o), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        @(negedge uclock);

        do_cmd(8'h00, 8'h00, 0, 0, 8'hA5);
        do_cmd(8'h0D, 8'h00, 0, 0, 8'h00);
        do_cmd(8'h01, 8'h00, 0, 0, 8'h00);
        do_cmd(8'h02, 8'h5A, 0, 0, 8'h00);
        do_cmd(8'h02, 8'h3C, 5, 0, 8'h00);
        do_cmd(8'h03, 8'h00, 0, 0, 8'h00);
        do_cmd(8'h00, 8'h00, 0, 4, 8'h77);

        // reset in the middle of a long advance aborts without a response
        send(8'hFD);
        repeat (9) @(negedge uclock);
        check("adv_en_before", 32'(cclock_en), 1);
        #2 reset = 1'b1;
        #1;
        check("abort_en", 32'(cclock_en), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ivalid", 32'(i_valid), 0);
        @(negedge uclock);
        reset = 1'b0;
        mdl_dat = 8'h00;
        check("abort_dat_o", 32'(dat_o), 0);
        quiet = 0;
        i_ready = 1'b1;
        for (int j = 0; j < 80; j++) begin
            quiet += int'(i_valid | cclock_en | busy);
            @(negedge uclock);
        end
        i_ready = 1'b0;
        check("abort_quiet", 32'(quiet), 0);
        do_cmd(8'h00, 8'h00, 0, 0, 8'h96);

        for (int k = 0; k < 40; k++)
            do_cmd(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), -1, 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
